// File: rtl/register_file_pkg.sv
// ============================================================================
// Module   : register_file_pkg
// Purpose  : Shared defaults, datapath typedefs and an address range helper
//            for the register_file block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;

  localparam int RF_WIDTH_DEFAULT = 11;
  localparam int RF_DEPTH_DEFAULT = 8;

  typedef logic [RF_WIDTH_DEFAULT-1:0]         rf_word_t;
  typedef logic [$clog2(RF_DEPTH_DEFAULT)-1:0] rf_addr_t;

  // DEPTH need not be a power of two, so the top address codes can be unused.
  function automatic logic addr_in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_write_decoder.sv
// ============================================================================
// Module   : rf_write_decoder
// Purpose  : Turns write request, address and clear into a one-hot per-entry
//            write enable; clear suppresses the write, out-of-range is dropped.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_write_decoder
  import register_file_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              rf_wr,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  input  logic              rf_clear,
  output logic [DEPTH-1:0]  wr_en
);

  logic wr_live;

  assign wr_live = rf_wr && !rf_clear && addr_in_range(32'(rf_wr_addr), DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_wr_en
    assign wr_en[i] = wr_live && (rf_wr_addr == ADDR_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Purpose  : DEPTH x WIDTH register bank, one write port, two combinational
//            read ports, synchronous clear-all and per-entry valid flags.
//            Optional same-cycle write forwarding: define RF_WRITE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter  int WIDTH  = RF_WIDTH_DEFAULT,
  parameter  int DEPTH  = RF_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rf_reset,
  input  logic              rf_wr,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  input  logic [WIDTH-1:0]  rf_in,
  input  logic              rf_clear,
  input  logic [ADDR_W-1:0] rf_rd_addr_a,
  input  logic [ADDR_W-1:0] rf_rd_addr_b,
  output logic [WIDTH-1:0]  rf_out_a,
  output logic [WIDTH-1:0]  rf_out_b,
  output logic [DEPTH-1:0]  rf_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_en;

  rf_write_decoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .rf_wr      (rf_wr),
    .rf_wr_addr (rf_wr_addr),
    .rf_clear   (rf_clear),
    .wr_en      (wr_en)
  );

  always_ff @(posedge clock or posedge rf_reset) begin
    if (rf_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rf_valid <= '0;
    end else if (rf_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rf_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem[i]      <= rf_in;
          rf_valid[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  logic wr_fwd;
  // Reset is included so forwarding never leaks data while the bank reads 0.
  assign wr_fwd = rf_wr && !rf_clear && !rf_reset &&
                  addr_in_range(32'(rf_wr_addr), DEPTH);
`endif

  always_comb begin
    rf_out_a = '0;
    rf_out_b = '0;
    if (addr_in_range(32'(rf_rd_addr_a), DEPTH)) rf_out_a = mem[rf_rd_addr_a];
    if (addr_in_range(32'(rf_rd_addr_b), DEPTH)) rf_out_b = mem[rf_rd_addr_b];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_fwd && (rf_rd_addr_a == rf_wr_addr)) rf_out_a = rf_in;
    if (wr_fwd && (rf_rd_addr_b == rf_wr_addr)) rf_out_b = rf_in;
`endif
  end

endmodule

`default_nettype wire
